// File: rtl/bch_decoder_if.sv
// bch_decoder_if: handshake bundle for the serial BCH decoder.
//   in_valid/in_ready/in_codeword  : received-word channel (producer -> decoder)
//   out_valid/out_ready            : result channel (decoder -> consumer)
//   out_message                    : decoded message
//   out_corrected/out_uncorrectable: status flags
//   out_err_pos                    : corrected bit index (0 when nothing corrected)
// Modport slave is the decoder side; master is the producer/consumer side.
interface bch_decoder_if #(
    parameter int MSG_W = 8,
    parameter int CW_W  = 14
);
    logic                      in_valid;
    logic                      in_ready;
    logic [CW_W-1:0]           in_codeword;
    logic                      out_valid;
    logic                      out_ready;
    logic [MSG_W-1:0]          out_message;
    logic                      out_corrected;
    logic                      out_uncorrectable;
    logic [$clog2(CW_W)-1:0]   out_err_pos;

    modport slave (
        input  in_valid, in_codeword, out_ready,
        output in_ready, out_valid, out_message, out_corrected,
               out_uncorrectable, out_err_pos
    );

    modport master (
        output in_valid, in_codeword, out_ready,
        input  in_ready, out_valid, out_message, out_corrected,
               out_uncorrectable, out_err_pos
    );
endinterface

// File: rtl/bch_decoder.sv
// bch_decoder: serial single-error-correcting decoder for the cyclic code
// generated by g(x) = x^5 + x^2 + 1 (codeword = m(x)*g(x), carry-less).
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : bch_decoder_if.slave (input word channel, result channel, flags)
// The word is divided by g one bit per cycle. A nonzero syndrome is matched
// against x^j mod g for j = 0..CW_W-1; on a hit bit j is flipped and the word
// is divided again to obtain the corrected message.
module bch_decoder #(
    parameter int         MSG_W = 8,
    parameter logic [5:0] GEN   = 6'b100101,
    parameter int         CW_W  = 14
) (
    input logic         clk,
    input logic         rst,
    bch_decoder_if.slave bus
);
    localparam int R     = 5;
    localparam int CNT_W = $clog2(CW_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CW_W - 1);

    typedef enum logic [2:0] {IDLE, DIVIDE, CHECK, SEARCH, DONE} state_t;

    state_t            state, state_nxt;
    logic [CW_W-1:0]   word;
    logic [R-1:0]      rem;
    logic [MSG_W:0]    quot;
    logic [CNT_W-1:0]  cnt;
    logic              pass;
    logic [R-1:0]      synd;
    logic [MSG_W-1:0]  quot_first;
    logic [R-1:0]      p;
    logic [CNT_W-1:0]  j;
    logic [CNT_W-1:0]  err_pos;

    logic [MSG_W-1:0]  out_msg_q;
    logic              out_corr_q;
    logic              out_unc_q;
    logic [CNT_W-1:0]  out_pos_q;

    logic accept;
    logic fb;

    // in_ready is gated by rst so it reads 0 for the whole reset pulse.
    assign bus.in_ready          = (state == IDLE) && rst;
    assign bus.out_valid         = (state == DONE);
    assign bus.out_message       = out_msg_q;
    assign bus.out_corrected     = out_corr_q;
    assign bus.out_uncorrectable = out_unc_q;
    assign bus.out_err_pos       = out_pos_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign fb     = rem[R-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (accept) state_nxt = DIVIDE;
            DIVIDE: if (cnt == '0) state_nxt = CHECK;
            CHECK:  state_nxt = (rem == '0 || pass) ? DONE : SEARCH;
            SEARCH: begin
                if (p == synd)     state_nxt = DIVIDE;
                else if (j == LAST) state_nxt = DONE;
            end
            DONE:   if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word       <= '0;
            rem        <= '0;
            quot       <= '0;
            cnt        <= '0;
            pass       <= 1'b0;
            synd       <= '0;
            quot_first <= '0;
            p          <= '0;
            j          <= '0;
            err_pos    <= '0;
            out_msg_q  <= '0;
            out_corr_q <= 1'b0;
            out_unc_q  <= 1'b0;
            out_pos_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        word <= bus.in_codeword;
                        rem  <= '0;
                        quot <= '0;
                        cnt  <= LAST;
                        pass <= 1'b0;
                    end
                end
                DIVIDE: begin
                    rem  <= {rem[R-2:0], word[cnt]} ^ (fb ? GEN[R-1:0] : '0);
                    quot <= {quot[MSG_W-1:0], fb};
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                CHECK: begin
                    if (rem == '0 || pass) begin
                        out_msg_q  <= quot[MSG_W-1:0];
                        out_unc_q  <= quot[MSG_W];
                        out_corr_q <= pass;
                        out_pos_q  <= pass ? err_pos : '0;
                    end else begin
                        synd       <= rem;
                        quot_first <= quot[MSG_W-1:0];
                        p          <= R'(1);
                        j          <= '0;
                    end
                end
                SEARCH: begin
                    if (p == synd) begin
                        word[j] <= ~word[j];
                        err_pos <= j;
                        pass    <= 1'b1;
                        rem     <= '0;
                        quot    <= '0;
                        cnt     <= LAST;
                    end else if (j == LAST) begin
                        // Syndrome is not any single-bit pattern: report raw quotient.
                        out_msg_q  <= quot_first;
                        out_unc_q  <= 1'b1;
                        out_corr_q <= 1'b0;
                        out_pos_q  <= '0;
                    end else begin
                        p <= p[R-1] ? ({p[R-2:0], 1'b0} ^ GEN[R-1:0]) : {p[R-2:0], 1'b0};
                        j <= j + 1'b1;
                    end
                end
                DONE: ;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bch_decoder.sv
// tb_bch_decoder: self-checking bench for bch_decoder. Expected results come
// from whole-word polynomial division and a brute-force single-bit search.
module tb_bch_decoder;
    localparam logic [5:0] G = 6'b100101;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bch_decoder_if #(.MSG_W(8), .CW_W(14)) bus ();

    bch_decoder #(.MSG_W(8), .GEN(6'b100101), .CW_W(14)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- reference model ----------------
    function automatic logic [13:0] clmul(input logic [7:0] m);
        logic [13:0] r = '0;
        for (int i = 0; i < 8; i++)
            if (m[i]) r = r ^ (14'(G) << i);
        return r;
    endfunction

    task automatic polydiv(input logic [13:0] a, output logic [8:0] q, output logic [4:0] r);
        logic [13:0] t = a;
        q = '0;
        for (int d = 13; d >= 5; d--) begin
            if (t[d]) begin
                t = t ^ (14'(G) << (d - 5));
                q[d-5] = 1'b1;
            end
        end
        r = t[4:0];
    endtask

    task automatic model(input logic [13:0] cw, output logic [7:0] msg, output logic corr,
                         output logic unc, output logic [3:0] pos, output int lat);
        logic [8:0] q, q2;
        logic [4:0] r, r2, xr;
        int hit = -1;
        polydiv(cw, q, r);
        if (r == '0) begin
            msg = q[7:0]; corr = 0; unc = q[8]; pos = 0; lat = 15;
            return;
        end
        for (int i = 0; i < 14; i++) begin
            polydiv(14'(1) << i, q2, xr);
            if (xr == r && hit < 0) hit = i;
        end
        if (hit < 0) begin
            msg = q[7:0]; corr = 0; unc = 1; pos = 0; lat = 29;
        end else begin
            polydiv(cw ^ (14'(1) << hit), q2, r2);
            msg = q2[7:0]; corr = 1; unc = q2[8]; pos = 4'(hit); lat = 31 + hit;
        end
    endtask

    // ---------------- driver (no checking beyond timeouts) ----------------
    task automatic run_word(input logic [13:0] cw, input bit ack, output int lat,
                            output logic [7:0] msg, output logic corr, output logic unc,
                            output logic [3:0] pos);
        int w = 0;
        while (bus.in_ready !== 1'b1 && w < 50) begin
            @(posedge clk); #1; w++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL in_ready_wait: in_ready=%b required 1", bus.in_ready);
        end
        bus.in_codeword = cw;
        bus.in_valid    = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        msg  = bus.out_message;
        corr = bus.out_corrected;
        unc  = bus.out_uncorrectable;
        pos  = bus.out_err_pos;
        if (ack) begin
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_message !== 8'h00 ||
            bus.out_corrected !== 1'b0 || bus.out_uncorrectable !== 1'b0 || bus.out_err_pos !== 4'h0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b vld=%b msg=%h c=%b u=%b pos=%0d required all 0",
                     bus.in_ready, bus.out_valid, bus.out_message, bus.out_corrected,
                     bus.out_uncorrectable, bus.out_err_pos);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle_ready: in_ready=%b required 1", bus.in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [13:0] cw  [6] = '{14'h1742, 14'h1752, 14'h3742, 14'h1741, 14'h2500, 14'h0000};
        logic [7:0]  emsg[6] = '{8'hAA, 8'hAA, 8'hAA, 8'h00, 8'h00, 8'h00};
        logic        ec  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        eu  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [3:0]  ep  [6] = '{4'd0, 4'd4, 4'd13, 4'd0, 4'd0, 4'd0};
        int          el  [6] = '{15, 35, 44, 29, 15, 15};
        int lat; logic [7:0] msg; logic c, u; logic [3:0] pos;
        for (int i = 0; i < 6; i++) begin
            run_word(cw[i], 1'b1, lat, msg, c, u, pos);
            checks++;
            if (lat !== el[i]) begin
                errors++; $display("FAIL dir_latency[%0h]: got %0d required %0d", cw[i], lat, el[i]);
            end
            // raw-quotient message of an uncorrectable word is only pinned for the zero-syndrome case
            if (!(eu[i] && ec[i] == 1'b0 && el[i] == 29)) begin
                checks++;
                if (msg !== emsg[i]) begin
                    errors++; $display("FAIL dir_message[%0h]: got %h required %h", cw[i], msg, emsg[i]);
                end
            end
            checks++;
            if (c !== ec[i] || u !== eu[i] || pos !== ep[i]) begin
                errors++;
                $display("FAIL dir_flags[%0h]: got c=%b u=%b pos=%0d required c=%b u=%b pos=%0d",
                         cw[i], c, u, pos, ec[i], eu[i], ep[i]);
            end
        end
    endtask

    task automatic test_random();
        int lat, elat; logic [7:0] msg, emsg, m; logic c, u, ec, eu; logic [3:0] pos, epos;
        logic [13:0] cw;
        int nerr, b1, b2;
        for (int n = 0; n < 40; n++) begin
            m    = 8'($urandom);
            cw   = clmul(m);
            nerr = $urandom_range(0, 2);
            b1   = $urandom_range(0, 13);
            b2   = (b1 + $urandom_range(1, 13)) % 14;
            if (nerr >= 1) cw[b1] = ~cw[b1];
            if (nerr == 2) cw[b2] = ~cw[b2];
            model(cw, emsg, ec, eu, epos, elat);
            run_word(cw, 1'b1, lat, msg, c, u, pos);
            checks++;
            if (msg !== emsg || c !== ec || u !== eu || pos !== epos || lat !== elat) begin
                errors++;
                $display("FAIL rand[%0h]: got msg=%h c=%b u=%b pos=%0d lat=%0d required msg=%h c=%b u=%b pos=%0d lat=%0d",
                         cw, msg, c, u, pos, lat, emsg, ec, eu, epos, elat);
            end
            if (nerr < 2) begin
                checks++;
                if (msg !== m) begin
                    errors++; $display("FAIL rand_recover[%0h]: got %h required %h", cw, msg, m);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat, w; logic [7:0] msg; logic c, u; logic [3:0] pos;
        logic [7:0] h_msg; logic h_c, h_u; logic [3:0] h_pos;
        run_word(14'h1752, 1'b0, lat, h_msg, h_c, h_u, h_pos);
        checks++;
        if (h_msg !== 8'hAA || h_c !== 1'b1 || h_pos !== 4'd4) begin
            errors++; $display("FAIL b2b_first: got msg=%h c=%b pos=%0d required AA 1 4", h_msg, h_c, h_pos);
        end
        // second word offered while the first result is stalled
        bus.in_codeword = 14'h3742;
        bus.in_valid    = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_message !== h_msg ||
                bus.out_corrected !== h_c || bus.out_uncorrectable !== h_u || bus.out_err_pos !== h_pos) begin
                errors++;
                $display("FAIL b2b_stall[%0d]: vld=%b rdy=%b msg=%h pos=%0d required vld=1 rdy=0 msg=%h pos=%0d",
                         k, bus.out_valid, bus.in_ready, bus.out_message, bus.out_err_pos, h_msg, h_pos);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_release: vld=%b rdy=%b required vld=0 rdy=1", bus.out_valid, bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        w = 0;
        while (bus.out_valid !== 1'b1 && w < 100) begin
            @(posedge clk); #1; w++;
        end
        checks++;
        if (w !== 44 || bus.out_message !== 8'hAA || bus.out_corrected !== 1'b1 || bus.out_err_pos !== 4'd13) begin
            errors++;
            $display("FAIL b2b_second: lat=%0d msg=%h c=%b pos=%0d required lat=44 msg=AA c=1 pos=13",
                     w, bus.out_message, bus.out_corrected, bus.out_err_pos);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat, w; logic [7:0] msg; logic c, u; logic [3:0] pos;
        run_word(14'h1742, 1'b1, lat, msg, c, u, pos);   // leaves nonzero held outputs
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 50) begin @(posedge clk); #1; w++; end
        bus.in_codeword = 14'h1752;
        bus.in_valid    = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (17) @(posedge clk);   // inside the syndrome search
        #1 rst = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_message !== 8'h00 ||
            bus.out_corrected !== 1'b0 || bus.out_uncorrectable !== 1'b0 || bus.out_err_pos !== 4'h0) begin
            errors++;
            $display("FAIL midreset_outputs: vld=%b rdy=%b msg=%h c=%b u=%b pos=%0d required all 0",
                     bus.out_valid, bus.in_ready, bus.out_message, bus.out_corrected,
                     bus.out_uncorrectable, bus.out_err_pos);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        run_word(14'h1742, 1'b1, lat, msg, c, u, pos);
        checks++;
        if (lat !== 15 || msg !== 8'hAA || c !== 1'b0 || u !== 1'b0 || pos !== 4'h0) begin
            errors++;
            $display("FAIL midreset_next: lat=%0d msg=%h c=%b u=%b pos=%0d required 15 AA 0 0 0",
                     lat, msg, c, u, pos);
        end
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_codeword = '0;
        bus.out_ready   = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
